// File: rtl/datapath_unit.sv
// ---------------------------------------------------------------------------
// datapath_unit
//
// Execution datapath that sits behind control_unit. It holds accumulator A
// and operand register B, executes the one-cycle ctl_* strobes, drives the
// data-memory port (address = B, write data = A) and buffers ctl_out values
// toward the host through an output queue.
//
// Configuration macro: DATAPATH_OUT_FIFO_EN
//   defined   -> output queue is an OUT_DEPTH-entry circular FIFO
//   undefined -> output queue is a single holding register (depth 1)
//
// Ports
//   clk, reset           clock; synchronous active-high reset
//   arg                  operand word from control_unit
//   ctl_*                execute strobes (hlt, arg, nad, shl, shr, acc,
//                        out, read, write), one cycle wide
//   alu_is_zero          A == 0, back to control_unit
//   dmem_addr/wdata      data-memory address (B) and write data (A)
//   dmem_rd_en/wr_en     data-memory read / write enables
//   dmem_rdata           synchronous read data, valid one cycle after rd_en
//   out_data/out_valid   head of the output queue / queue non-empty
//   out_ready            host accepts the head entry
//   halted               sticky after ctl_hlt
//   out_overflow         sticky: a ctl_out value was dropped (queue full)
// ---------------------------------------------------------------------------
module datapath_unit #(
  parameter int WIDTH     = 16,
  parameter int OUT_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] arg,
  input  logic             ctl_hlt,
  input  logic             ctl_arg,
  input  logic             ctl_nad,
  input  logic             ctl_shl,
  input  logic             ctl_shr,
  input  logic             ctl_acc,
  input  logic             ctl_out,
  input  logic             ctl_read,
  input  logic             ctl_write,
  output logic             alu_is_zero,
  output logic [WIDTH-1:0] dmem_addr,
  output logic             dmem_rd_en,
  output logic             dmem_wr_en,
  output logic [WIDTH-1:0] dmem_wdata,
  input  logic [WIDTH-1:0] dmem_rdata,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             halted,
  output logic             out_overflow
);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_HLT   = 4'd1,
    OP_READ  = 4'd2,
    OP_WRITE = 4'd3,
    OP_OUT   = 4'd4,
    OP_ARG   = 4'd5,
    OP_ACC   = 4'd6,
    OP_NAD   = 4'd7,
    OP_SHL   = 4'd8,
    OP_SHR   = 4'd9
  } op_e;

  op_e              op_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             rd_pending_r;
  logic             push_s;
  logic             pop_s;
  logic             accept_s;

  // Pick the single winning strobe; everything is ignored once halted.
  always_comb begin
    op_s = OP_NONE;
    if (halted)         op_s = OP_NONE;
    else if (ctl_hlt)   op_s = OP_HLT;
    else if (ctl_read)  op_s = OP_READ;
    else if (ctl_write) op_s = OP_WRITE;
    else if (ctl_out)   op_s = OP_OUT;
    else if (ctl_arg)   op_s = OP_ARG;
    else if (ctl_acc)   op_s = OP_ACC;
    else if (ctl_nad)   op_s = OP_NAD;
    else if (ctl_shl)   op_s = OP_SHL;
    else if (ctl_shr)   op_s = OP_SHR;
    else                op_s = OP_NONE;
  end

  // Memory port and status outputs are direct views of the registers.
  assign alu_is_zero = (a_r == {WIDTH{1'b0}});
  assign dmem_addr   = b_r;
  assign dmem_wdata  = a_r;
  assign dmem_rd_en  = ctl_read && !halted;
  assign dmem_wr_en  = ctl_write && !halted;

  // Accumulator, operand register, load tracking and halt flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r          <= {WIDTH{1'b0}};
      b_r          <= {WIDTH{1'b0}};
      rd_pending_r <= 1'b0;
      halted       <= 1'b0;
    end else begin
      // An A-writing strobe in the load cycle overrides the returning data.
      case (op_s)
        OP_NAD:  a_r <= ~(a_r & b_r);
        OP_SHL:  a_r <= {a_r[WIDTH-2:0], 1'b0};
        OP_SHR:  a_r <= {1'b0, a_r[WIDTH-1:1]};
        default: begin
          if (rd_pending_r) a_r <= dmem_rdata;
          else              a_r <= a_r;
        end
      endcase

      case (op_s)
        OP_ARG:  b_r <= arg;
        OP_ACC:  b_r <= a_r;
        default: b_r <= b_r;
      endcase

      // A pending load still lands after halt; a new read re-arms.
      rd_pending_r <= (op_s == OP_READ);

      if (op_s == OP_HLT) halted <= 1'b1;
      else                halted <= halted;
    end
  end

  assign push_s = (op_s == OP_OUT);
  assign pop_s  = out_valid && out_ready;

`ifdef DATAPATH_OUT_FIFO_EN

  localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(OUT_DEPTH);

  logic [WIDTH-1:0] q_mem_r [OUT_DEPTH];
  logic [PW-1:0]    rd_ptr_r;
  logic [PW-1:0]    wr_ptr_r;
  logic [CW-1:0]    count_r;
  logic             full_s;

  assign full_s = (count_r == FULL_CNT);
  // A pop in the same cycle frees the slot the push needs.
  assign accept_s = push_s && (!full_s || pop_s);

  // Queue storage; contents are don't-care while the slot is empty.
  always_ff @(posedge clk) begin
    if (accept_s) q_mem_r[wr_ptr_r] <= a_r;
  end

  // Pointers, occupancy and overflow flag; pointers wrap at OUT_DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_r     <= {PW{1'b0}};
      wr_ptr_r     <= {PW{1'b0}};
      count_r      <= {CW{1'b0}};
      out_overflow <= 1'b0;
    end else begin
      if (accept_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      else          wr_ptr_r <= wr_ptr_r;

      if (pop_s) rd_ptr_r <= rd_ptr_r + PW'(1);
      else       rd_ptr_r <= rd_ptr_r;

      case ({accept_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase

      if (push_s && full_s && !pop_s) out_overflow <= 1'b1;
      else                            out_overflow <= out_overflow;
    end
  end

  // Head of queue straight from storage; zero when empty.
  always_comb begin
    out_valid = (count_r != {CW{1'b0}});
    if (out_valid) out_data = q_mem_r[rd_ptr_r];
    else           out_data = {WIDTH{1'b0}};
  end

`else

  localparam int OUT_DEPTH_UNUSED = OUT_DEPTH;

  logic [WIDTH-1:0] hold_data_r;
  logic             hold_valid_r;

  assign accept_s = push_s && (!hold_valid_r || pop_s);

  // Single holding register in place of the FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_data_r  <= {WIDTH{1'b0}};
      hold_valid_r <= 1'b0;
      out_overflow <= 1'b0;
    end else begin
      if (accept_s) begin
        hold_data_r  <= a_r;
        hold_valid_r <= 1'b1;
      end else if (pop_s) begin
        hold_data_r  <= hold_data_r;
        hold_valid_r <= 1'b0;
      end else begin
        hold_data_r  <= hold_data_r;
        hold_valid_r <= hold_valid_r;
      end

      if (push_s && hold_valid_r && !pop_s) out_overflow <= 1'b1;
      else                                  out_overflow <= out_overflow;
    end
  end

  // Holding register view; zero when empty.
  always_comb begin
    out_valid = hold_valid_r;
    if (hold_valid_r) out_data = hold_data_r;
    else              out_data = {WIDTH{1'b0}};
  end

`endif

endmodule

// File: tb/tb_datapath_unit.sv
// ---------------------------------------------------------------------------
// tb_datapath_unit
//
// Self-checking bench for datapath_unit. A behavioural model (plain variables,
// a memory array and a queue) tracks A, B, halt/overflow flags, the load in
// flight and the output queue. Directed sequences cover the documented
// scenarios, then randomized strobes run against the same model.
// Works with DATAPATH_OUT_FIFO_EN defined or undefined.
// ---------------------------------------------------------------------------
module tb_datapath_unit;

`ifdef DATAPATH_OUT_FIFO_EN
  localparam int QCAP = 4;
`else
  localparam int QCAP = 1;
`endif

  // strobe bit positions; higher index = higher priority
  localparam int S_HLT = 8, S_RD = 7, S_WR = 6, S_OUT = 5, S_ARG = 4;
  localparam int S_ACC = 3, S_NAD = 2, S_SHL = 1, S_SHR = 0;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] arg;
  logic        ctl_hlt, ctl_arg, ctl_nad, ctl_shl, ctl_shr;
  logic        ctl_acc, ctl_out, ctl_read, ctl_write;
  logic        alu_is_zero;
  logic [15:0] dmem_addr;
  logic        dmem_rd_en, dmem_wr_en;
  logic [15:0] dmem_wdata;
  logic [15:0] dmem_rdata = 16'h0000;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        halted;
  logic        out_overflow;

  always #5 clk = ~clk;

  datapath_unit #(.WIDTH(16), .OUT_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .arg(arg),
    .ctl_hlt(ctl_hlt), .ctl_arg(ctl_arg), .ctl_nad(ctl_nad),
    .ctl_shl(ctl_shl), .ctl_shr(ctl_shr), .ctl_acc(ctl_acc),
    .ctl_out(ctl_out), .ctl_read(ctl_read), .ctl_write(ctl_write),
    .alu_is_zero(alu_is_zero), .dmem_addr(dmem_addr),
    .dmem_rd_en(dmem_rd_en), .dmem_wr_en(dmem_wr_en),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .halted(halted), .out_overflow(out_overflow)
  );

  // environment memory (256 words, address aliased mod 256)
  logic        pre_we = 1'b0;
  logic [7:0]  pre_addr = 8'h00;
  logic [15:0] pre_data = 16'h0000;
  logic [15:0] env_mem [0:255];

  always @(posedge clk) begin
    if (dmem_rd_en) dmem_rdata <= env_mem[dmem_addr[7:0]];
    if (dmem_wr_en) env_mem[dmem_addr[7:0]] <= dmem_wdata;
    if (pre_we)     env_mem[pre_addr] <= pre_data;
  end

  // behavioural model state
  logic [15:0] m_a, m_b, m_load;
  logic        m_halted, m_ovf, m_pend;
  logic [15:0] m_mem [0:255];
  logic [15:0] m_q [$];

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic [8:0] s);
    ctl_hlt = s[S_HLT]; ctl_read = s[S_RD]; ctl_write = s[S_WR];
    ctl_out = s[S_OUT]; ctl_arg  = s[S_ARG]; ctl_acc  = s[S_ACC];
    ctl_nad = s[S_NAD]; ctl_shl  = s[S_SHL]; ctl_shr  = s[S_SHR];
  endtask

  task automatic check_state();
    chk("A", dmem_wdata, m_a);
    chk("B", dmem_addr, m_b);
    chk("zero", alu_is_zero, m_a == 16'h0000);
    chk("halted", halted, m_halted);
    chk("overflow", out_overflow, m_ovf);
    chk("out_valid", out_valid, m_q.size() != 0);
    chk("out_data", out_data, (m_q.size() != 0) ? m_q[0] : 16'h0000);
  endtask

  // model of one clock edge with strobes s, operand a, host ready rdy
  task automatic model_step(input logic [8:0] s, input logic [15:0] a, input logic rdy);
    int w;
    logic [15:0] na, nb;
    logic npend;
    w = -1;
    if (!m_halted)
      for (int i = 8; i >= 0; i--)
        if (s[i]) begin w = i; break; end
    na = m_pend ? m_load : m_a;
    nb = m_b;
    npend = 1'b0;
    if (w == S_RD) begin
      npend = 1'b1;
      m_load = m_mem[m_b[7:0]];
    end
    if (s[S_WR] && !m_halted) m_mem[m_b[7:0]] = m_a;
    if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
    case (w)
      S_HLT: m_halted = 1'b1;
      S_OUT: if (m_q.size() < QCAP) m_q.push_back(m_a); else m_ovf = 1'b1;
      S_ARG: nb = a;
      S_ACC: nb = m_a;
      S_NAD: na = ~(m_a & m_b);
      S_SHL: na = m_a << 1;
      S_SHR: na = m_a >> 1;
      default: ;
    endcase
    m_a = na;
    m_b = nb;
    m_pend = npend;
  endtask

  // one cycle: drive, check memory enables, clock, update model, check state
  task automatic apply(input logic [8:0] s, input logic [15:0] a, input logic rdy);
    drive(s);
    arg = a;
    out_ready = rdy;
    #1;
    chk("rd_en", dmem_rd_en, s[S_RD] && !m_halted);
    chk("wr_en", dmem_wr_en, s[S_WR] && !m_halted);
    @(posedge clk);
    model_step(s, a, rdy);
    #1;
    check_state();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(9'h000);
    arg = 16'h0000;
    out_ready = 1'b0;
    @(posedge clk);
    m_a = 16'h0000; m_b = 16'h0000; m_halted = 1'b0;
    m_ovf = 1'b0; m_pend = 1'b0; m_q.delete();
    #1;
    check_state();
    reset = 1'b0;
  endtask

  task automatic poke(input logic [7:0] addr, input logic [15:0] data);
    pre_we = 1'b1; pre_addr = addr; pre_data = data;
    m_mem[addr] = data;
    apply(9'h000, 16'h0000, 1'b0);
    pre_we = 1'b0;
  endtask

  // B <= addr, then read and let the load land
  task automatic load_a(input logic [15:0] addr);
    apply(9'h001 << S_ARG, addr, 1'b0);
    apply(9'h001 << S_RD, 16'h0000, 1'b0);
    apply(9'h000, 16'h0000, 1'b0);
  endtask

  initial begin
    logic [8:0]  s;
    logic [15:0] last;
    int          n;
    int          r;

    do_reset();
    chk("reset_out_data", out_data, 16'h0000);
    for (int i = 0; i < 256; i++) poke(i[7:0], 16'($urandom));

    // 1: acc, arg 0x00F0, nad
    do_reset();
    apply(9'h001 << S_ACC, 16'h0000, 1'b0);
    apply(9'h001 << S_ARG, 16'h00F0, 1'b0);
    apply(9'h001 << S_NAD, 16'h0000, 1'b0);
    chk("t1_a", dmem_wdata, 16'hFFFF);
    chk("t1_b", dmem_addr, 16'h00F0);
    chk("t1_zero", alu_is_zero, 1'b0);

    // 2: shifts drop the outgoing bit
    poke(8'h20, 16'h8001);
    load_a(16'h0020);
    apply(9'h001 << S_SHL, 16'h0000, 1'b0);
    chk("t2_shl", dmem_wdata, 16'h0002);
    apply(9'h001 << S_SHR, 16'h0000, 1'b0);
    apply(9'h001 << S_SHR, 16'h0000, 1'b0);
    chk("t2_shr", dmem_wdata, 16'h0000);
    chk("t2_zero", alu_is_zero, 1'b1);

    // 3: load latency and A-writing strobe in the load cycle
    poke(8'h10, 16'hBEEF);
    load_a(16'h0010);
    chk("t3_load", dmem_wdata, 16'hBEEF);
    poke(8'h10, 16'h1234);
    apply(9'h001 << S_RD, 16'h0000, 1'b0);
    apply(9'h001 << S_SHL, 16'h0000, 1'b0);
    chk("t3_shl_wins", dmem_wdata, 16'h7DDE);
    // read in the load cycle: load lands, then the new one
    poke(8'h10, 16'h0101);
    apply(9'h001 << S_RD, 16'h0000, 1'b0);
    apply(9'h001 << S_RD, 16'h0000, 1'b0);
    chk("t3_reread", dmem_wdata, 16'h0101);
    apply(9'h000, 16'h0000, 1'b0);

    // 4: fill past capacity with 1..5, then drain in order
    do_reset();
    for (int k = 1; k <= 5; k++) poke(8'hC0 + 8'(k), 16'(k));
    for (int k = 1; k <= 5; k++) begin
      load_a(16'h00C0 + 16'(k));
      apply(9'h001 << S_OUT, 16'h0000, 1'b0);
    end
    chk("t4_overflow", out_overflow, 1'b1);
    for (int k = 1; k <= QCAP; k++) begin
      chk("t4_pop", out_data, 16'(k));
      apply(9'h000, 16'h0000, 1'b1);
    end
    chk("t4_empty", out_valid, 1'b0);

    // 6: push and pop on a full queue
    do_reset();
    for (int k = 0; k < QCAP; k++) apply(9'h001 << S_OUT, 16'h0000, 1'b0);
    poke(8'h55, 16'h5A5A);
    load_a(16'h0055);
    apply(9'h001 << S_OUT, 16'h0000, 1'b1);
    chk("t6_no_overflow", out_overflow, 1'b0);
    n = 0;
    last = 16'h0000;
    for (int i = 0; i < QCAP + 2; i++)
      if (out_valid) begin
        last = out_data;
        n++;
        apply(9'h000, 16'h0000, 1'b1);
      end
    chk("t6_count", 32'(n), 32'(QCAP));
    chk("t6_tail", last, 16'h5A5A);

    // reset mid-operation: queued data and pending load are dropped
    poke(8'h30, 16'hCAFE);
    apply(9'h001 << S_OUT, 16'h0000, 1'b0);
    apply(9'h001 << S_ARG, 16'h0030, 1'b0);
    apply(9'h001 << S_RD, 16'h0000, 1'b0);
    do_reset();
    apply(9'h000, 16'h0000, 1'b0);
    chk("rst_mid_a", dmem_wdata, 16'h0000);
    chk("rst_mid_valid", out_valid, 1'b0);

    // 5: halted ignores strobes; reset clears
    apply(9'h001 << S_ARG, 16'h0042, 1'b0);
    apply(9'h001 << S_HLT, 16'h0000, 1'b0);
    apply(9'h001 << S_ARG, 16'h1234, 1'b0);
    apply(9'h001 << S_WR, 16'h0000, 1'b0);
    chk("t5_b", dmem_addr, 16'h0042);
    chk("t5_halted", halted, 1'b1);
    do_reset();
    chk("t5_rst_halted", halted, 1'b0);
    chk("t5_rst_b", dmem_addr, 16'h0000);

    // priority among non-memory strobes
    apply((9'h001 << S_ARG) | (9'h001 << S_ACC), 16'h0077, 1'b0);
    chk("prio_arg_acc", dmem_addr, 16'h0077);

    // randomized run; halt allowed only near the end
    for (int c = 0; c < 500; c++) begin
      s = 9'h000;
      r = $urandom_range(0, 9);
      if (r < 7) s = 9'h001 << $urandom_range(0, 7);
      else if (r == 7) s = 9'($urandom_range(0, 63));
      if (c > 470 && $urandom_range(0, 9) == 0) s = 9'h001 << S_HLT;
      apply(s, 16'($urandom), 1'($urandom_range(0, 1)));
    end
    do_reset();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
